ts_os_gen: RTL
==============

TS_OS_GEN -- requirements
Module: ts_os_gen

Interface
REQ-001 SHALL have a single clock domain clk_i; rst_i SHALL be synchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  request TS ordered sets (Polling/Configuration transmit enable)
- ts2_i  in  1  0 = TS1, 1 = TS2
- link_pad_i  in  1  send PAD in link field
- link_num_i  in  8  link number
- lane_pad_i  in  1  send PAD in lane field
- lane_num_i  in  5  lane number, 0..31
- n_fts_i  in  8  N_FTS value
- rate_id_i  in  8  data rate identifier
- train_ctl_i  in  8  training control
- sym_ready_i  in  1  downstream 8b10b encoder accepts symbol
- cnt_clr_i  in  1  clear completed-OS counter
- sym_o  out  8  symbol byte
- sym_k_o  out  1  symbol is K-character
- sym_valid_o  out  1  symbol valid
- os_start_o  out  1  current symbol is symbol 0 (COM)
- os_done_o  out  1  symbol 15 accepted this cycle
- busy_o  out  1  FSM not IDLE
- os_count_o  out  16  completed ordered sets, saturating

Function
REQ-003 SHALL implement FSM with states IDLE and SEND, plus a 4-bit symbol index idx (0..15).
REQ-004 In IDLE, en_i = 1 SHALL cause transition to SEND at the next edge with idx = 0; sym_valid_o SHALL be 1 from the first SEND cycle.
REQ-005 On every entry to idx = 0, the FSM SHALL capture all field inputs (ts2_i, pads, link, lane, n_fts, rate, train_ctl); fields SHALL remain constant for all 16 symbols.
REQ-006 Symbol map (byte / K):
- idx 0: 0xBC K (COM, K28.5)
- idx 1: link_pad ? 0xF7 K (PAD, K23.7) : link_num D
- idx 2: lane_pad ? 0xF7 K : {3'b000, lane_num} D
- idx 3: n_fts D
- idx 4: rate_id D
- idx 5: train_ctl D
- idx 6..15: 0x4A D (TS1, D10.2) or 0x45 D (TS2, D5.2)
REQ-007 Handshake: a symbol transfers when sym_valid_o & sym_ready_i; idx SHALL advance only on transfer; sym_o, sym_k_o and os_start_o SHALL be held stable while sym_valid_o = 1 and sym_ready_i = 0.
REQ-008 sym_valid_o SHALL NOT deassert mid-OS; an OS is never truncated, including when en_i drops.
REQ-009 On transfer at idx 15: if en_i = 1, idx SHALL wrap to 0 with sym_valid_o remaining 1 (no bubble) and fields recaptured; else the FSM SHALL return to IDLE with sym_valid_o = 0 in the next cycle.
REQ-010 os_start_o SHALL be 1 exactly when SEND and idx = 0.
REQ-011 os_done_o SHALL be combinational, asserted in the cycle of the idx 15 transfer.
REQ-012 os_count_o SHALL increment by 1 on each os_done_o and saturate at 0xFFFF.
REQ-013 cnt_clr_i SHALL set os_count_o to 0 at the next edge; if os_done_o occurs in the same cycle, clear SHALL win (result 0).
REQ-014 busy_o SHALL equal (state == SEND).
REQ-015 Toggling en_i in IDLE for a single cycle SHALL produce exactly one full OS.

Reset
REQ-016 With rst_i = 1 at an edge: state = IDLE, idx = 0, os_count_o = 0, sym_valid_o = 0, os_start_o = 0, busy_o = 0, sym_o = 0x00, sym_k_o = 0, captured fields = 0.
REQ-017 Reset asserted mid-OS SHALL abort the OS immediately with no os_done_o and no count increment; the next OS after reset SHALL start at COM.

Verification
REQ-018 en_i pulse 1 cycle, ts2_i = 0, link_pad_i = lane_pad_i = 1, n_fts_i = 0x20, rate_id_i = 0x02, train_ctl_i = 0x00, ready = 1 -> 16 consecutive symbols BC(K) F7(K) F7(K) 20 02 00 then 4A x10, os_done_o on the 16th, os_count_o = 1, then IDLE.
REQ-019 en_i held high, ts2_i = 1, link 0x05, lane 3, ready = 1 -> back-to-back OSes, no idle cycle between idx 15 and next COM, symbol 2 = 0x03 D, symbols 6..15 = 0x45.
REQ-020 sym_ready_i low for 3 cycles at idx 4 -> rate_id symbol held stable for 4 cycles, no skipped or duplicated symbol, total OS length 16 transfers.
REQ-021 Change link_num_i mid-OS (0x05 to 0x09) with en_i high -> current OS carries 0x05; next OS carries 0x09.
REQ-022 rst_i asserted at idx 8 -> next cycle sym_valid_o = 0, os_count_o = 0; with en_i high after reset, first symbol is BC(K).
REQ-023 Preload os_count_o to 0xFFFF via 65535 OSes (or force), complete another OS -> stays 0xFFFF; cnt_clr_i coincident with os_done_o -> 0.

Source files
------------

// File: rtl/ts_os_gen_if.sv
// ---------------------------------------------------------------------------
// ts_os_gen_if
// Control, field and symbol-stream signals of the TS1/TS2 ordered-set
// generator. The master drives the requests and fields. The slave is the
// generator.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface ts_os_gen_if;
  logic        en_i;
  logic        ts2_i;
  logic        link_pad_i;
  logic [7:0]  link_num_i;
  logic        lane_pad_i;
  logic [4:0]  lane_num_i;
  logic [7:0]  n_fts_i;
  logic [7:0]  rate_id_i;
  logic [7:0]  train_ctl_i;
  logic        sym_ready_i;
  logic        cnt_clr_i;
  logic [7:0]  sym_o;
  logic        sym_k_o;
  logic        sym_valid_o;
  logic        os_start_o;
  logic        os_done_o;
  logic        busy_o;
  logic [15:0] os_count_o;

  modport master (
    output en_i, ts2_i, link_pad_i, link_num_i, lane_pad_i, lane_num_i,
           n_fts_i, rate_id_i, train_ctl_i, sym_ready_i, cnt_clr_i,
    input  sym_o, sym_k_o, sym_valid_o, os_start_o, os_done_o, busy_o,
           os_count_o
  );

  modport slave (
    input  en_i, ts2_i, link_pad_i, link_num_i, lane_pad_i, lane_num_i,
           n_fts_i, rate_id_i, train_ctl_i, sym_ready_i, cnt_clr_i,
    output sym_o, sym_k_o, sym_valid_o, os_start_o, os_done_o, busy_o,
           os_count_o
  );
endinterface

`default_nettype wire

// File: rtl/ts_os_gen.sv
// ---------------------------------------------------------------------------
// ts_os_gen
// Emits 16-symbol TS1/TS2 training ordered sets over a valid/ready symbol
// stream. Field inputs are latched at every COM so that each set is
// self-consistent. A saturating counter tracks the number of completed sets.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ts_os_gen (
  input  wire logic   clk_i,
  input  wire logic   rst_i,
  ts_os_gen_if.slave  bus
);

  localparam logic [7:0]  C_COM     = 8'hBC;
  localparam logic [7:0]  C_PAD     = 8'hF7;
  localparam logic [7:0]  C_TS1_ID  = 8'h4A;
  localparam logic [7:0]  C_TS2_ID  = 8'h45;
  localparam logic [3:0]  C_IDX_MAX = 4'd15;
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt;
  logic        w_capture;
  logic        w_xfer;
  logic        w_done;

  logic        r_ts2;
  logic        r_link_pad;
  logic [7:0]  r_link_num;
  logic        r_lane_pad;
  logic [4:0]  r_lane_num;
  logic [7:0]  r_n_fts;
  logic [7:0]  r_rate_id;
  logic [7:0]  r_train_ctl;
  logic [15:0] r_os_count;

  logic [7:0]  w_sym;
  logic        w_sym_k;

  assign w_xfer = (r_state == S_SEND) && bus.sym_ready_i;
  assign w_done = w_xfer && (r_idx == C_IDX_MAX);

  // State and symbol index register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: the index advances only on a transfer, and a set always runs to idx 15
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en_i) begin
          w_state_nxt = S_SEND;
          w_idx_nxt   = 4'd0;
          w_capture   = 1'b1;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          if (r_idx == C_IDX_MAX) begin
            w_idx_nxt = 4'd0;
            if (bus.en_i) begin
              w_capture = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 4'd0;
      end
    endcase
  end

  // Field snapshot taken whenever the next symbol will be COM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ts2       <= 1'b0;
      r_link_pad  <= 1'b0;
      r_link_num  <= 8'd0;
      r_lane_pad  <= 1'b0;
      r_lane_num  <= 5'd0;
      r_n_fts     <= 8'd0;
      r_rate_id   <= 8'd0;
      r_train_ctl <= 8'd0;
    end else if (w_capture) begin
      r_ts2       <= bus.ts2_i;
      r_link_pad  <= bus.link_pad_i;
      r_link_num  <= bus.link_num_i;
      r_lane_pad  <= bus.lane_pad_i;
      r_lane_num  <= bus.lane_num_i;
      r_n_fts     <= bus.n_fts_i;
      r_rate_id   <= bus.rate_id_i;
      r_train_ctl <= bus.train_ctl_i;
    end
  end

  // Completed-set counter; a clear takes priority over a coincident completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_os_count <= 16'd0;
    end else if (bus.cnt_clr_i) begin
      r_os_count <= 16'd0;
    end else if (w_done && (r_os_count != C_CNT_MAX)) begin
      r_os_count <= r_os_count + 16'd1;
    end
  end

  // Symbol map. Only registered state feeds it, so the output holds steady under backpressure
  always_comb begin
    w_sym   = 8'h00;
    w_sym_k = 1'b0;
    if (r_state == S_SEND) begin
      case (r_idx)
        4'd0: begin
          w_sym   = C_COM;
          w_sym_k = 1'b1;
        end
        4'd1: begin
          w_sym   = r_link_pad ? C_PAD : r_link_num;
          w_sym_k = r_link_pad;
        end
        4'd2: begin
          w_sym   = r_lane_pad ? C_PAD : {3'b000, r_lane_num};
          w_sym_k = r_lane_pad;
        end
        4'd3:    w_sym = r_n_fts;
        4'd4:    w_sym = r_rate_id;
        4'd5:    w_sym = r_train_ctl;
        default: w_sym = r_ts2 ? C_TS2_ID : C_TS1_ID;
      endcase
    end
  end

  assign bus.sym_o       = w_sym;
  assign bus.sym_k_o     = w_sym_k;
  assign bus.sym_valid_o = (r_state == S_SEND);
  assign bus.os_start_o  = (r_state == S_SEND) && (r_idx == 4'd0);
  assign bus.os_done_o   = w_done;
  assign bus.busy_o      = (r_state == S_SEND);
  assign bus.os_count_o  = r_os_count;

endmodule

`default_nettype wire
